// File: rtl/trace_recorder.sv
// Trace-line writer: buffers LLC trace transactions in a FIFO and serialises each
// one as an ASCII line "<cmd> <addr>\n" (or "<cmd>\n" for cmd 8/9), one byte per handshake.
module trace_recorder #(
    parameter int CMDSIZE    = 4,
    parameter int ADDR_BITS  = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CMDSIZE-1:0]   in_cmd,
    input  logic [ADDR_BITS-1:0] in_addr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [7:0]           out_byte,
    output logic [CNT_W-1:0]     rec_count,
    output logic [CNT_W-1:0]     drop_count,
    output logic                 busy
);

    localparam int HEXD = (ADDR_BITS + 3) / 4;
    localparam int PADW = HEXD * 4;
    localparam int IDXW = (HEXD > 1) ? $clog2(HEXD) : 1;
    localparam int PTRW = $clog2(FIFO_DEPTH);
    localparam int RECW = CMDSIZE + ADDR_BITS;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CMD   = 3'd1;
    localparam logic [2:0] S_SPACE = 3'd2;
    localparam logic [2:0] S_ADDR  = 3'd3;
    localparam logic [2:0] S_NL    = 3'd4;

    localparam logic [CMDSIZE-1:0] CMD_MAX   = CMDSIZE'(9);
    localparam logic [CMDSIZE-1:0] CMD_SHORT = CMDSIZE'(8);

    logic [RECW-1:0]      mem [FIFO_DEPTH];
    logic [PTRW-1:0]      wptr, rptr;
    logic [PTRW:0]        count;
    logic                 empty, full, in_xfer, push, drop, pop;

    logic [2:0]           state;
    logic [CMDSIZE-1:0]   rec_cmd;
    logic [ADDR_BITS-1:0] rec_addr;
    logic [IDXW-1:0]      idx;
    logic [PADW-1:0]      addr_pad;
    logic [3:0]           nib;

    assign empty    = (count == '0);
    assign full     = (count == (PTRW+1)'(FIFO_DEPTH));
    assign in_ready = !full;
    assign in_xfer  = in_valid && in_ready;
    assign push     = in_xfer && (in_cmd <= CMD_MAX);
    assign drop     = in_xfer && (in_cmd > CMD_MAX);
    // Pop only looks at registered occupancy, so a same-cycle push is never bypassed.
    assign pop      = (state == S_IDLE) && !empty;
    assign busy     = !empty || (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= {in_cmd, in_addr};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            drop_count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            if (drop && (drop_count != '1)) drop_count <= drop_count + 1'b1;
        end
    end

    // out_valid is high in every non-IDLE state, so out_ready alone marks an accept there.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            rec_cmd   <= '0;
            rec_addr  <= '0;
            idx       <= '0;
            rec_count <= '0;
        end else begin
            case (state)
                S_IDLE: if (pop) begin
                    {rec_cmd, rec_addr} <= mem[rptr];
                    state               <= S_CMD;
                end
                S_CMD: if (out_ready)
                    state <= (rec_cmd < CMD_SHORT) ? S_SPACE : S_NL;
                S_SPACE: if (out_ready) begin
                    state <= S_ADDR;
                    idx   <= IDXW'(HEXD - 1);
                end
                S_ADDR: if (out_ready) begin
                    if (idx == '0) state <= S_NL;
                    else           idx   <= idx - 1'b1;
                end
                S_NL: if (out_ready) begin
                    state <= S_IDLE;
                    if (rec_count != '1) rec_count <= rec_count + 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Zero-extend so a partial top nibble prints as a padded hex digit.
    assign addr_pad  = PADW'(rec_addr);
    assign nib       = 4'(addr_pad >> {idx, 2'b00});
    assign out_valid = (state != S_IDLE);

    always_comb begin
        out_byte = 8'h00;
        case (state)
            S_CMD:   out_byte = 8'h30 + 8'(rec_cmd);
            S_SPACE: out_byte = 8'h20;
            S_ADDR:  out_byte = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h57 + {4'h0, nib});
            S_NL:    out_byte = 8'h0A;
            default: out_byte = 8'h00;
        endcase
    end

endmodule

// File: doc/trace_recorder.md
Name: trace_recorder

Overview:
- Write-side counterpart of the trace-file reader that feeds the LLC.
- Accepts LLC trace transactions (command plus address) over a valid/ready interface and buffers them in a FIFO.
- Serialises each transaction into the ASCII trace-line format the reader consumes: "<cmd> <addr>\n" for commands 0-7, "<cmd>\n" for commands 8 and 9.
- Emits one byte per handshake toward a file/console sink, so captured or generated traffic can be replayed as trace files.

Parameters:
- CMDSIZE, 4, command field width (matches defines.sv).
- ADDR_BITS, 32, address width. Hex digit count HEXD = ceil(ADDR_BITS/4).
- FIFO_DEPTH, 8, transaction FIFO entries. Must be a power of two, >= 2.
- CNT_W, 32, width of the statistics counters.

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  transaction valid.
- in_ready  out  1  recorder can accept; equals !fifo_full.
- in_cmd  in  CMDSIZE  trace command.
- in_addr  in  ADDR_BITS  trace address (ignored for cmd >= 8).
- out_valid  out  1  out_byte valid.
- out_ready  in  1  sink accepts byte.
- out_byte  out  8  ASCII character.
- rec_count  out  CNT_W  lines fully emitted (newline byte accepted).
- drop_count  out  CNT_W  transactions dropped for illegal command (> 9).
- busy  out  1  FIFO non-empty or FSM not IDLE.

Behaviour:
- Reset values (asynchronous, immediate):
  - FIFO empty, so in_ready=1.
  - FSM in IDLE, out_valid=0, out_byte=8'h00.
  - rec_count=0, drop_count=0, busy=0.
- Reset mid-line abandons the partial line; no further bytes of that line are emitted after reset.
- Input handshake: a transfer occurs on a clock edge with in_valid && in_ready.
  - cmd <= 9: {cmd, addr} is pushed into the FIFO.
  - cmd > 9: the transaction is consumed but not pushed, and drop_count increments.
- in_ready depends only on FIFO occupancy (no combinational path from out_ready).
- FIFO full: in_ready=0; a held in_valid waits. A pop in a cycle raises in_ready the following cycle only.
- FSM states: IDLE, CMD, SPACE, ADDR, NL.
  - IDLE: out_valid=0. If the FIFO is non-empty, pop into the record register and go to CMD on the next edge.
  - CMD: out_byte = 8'h30 + cmd. On accept: cmd < 8 goes to SPACE; cmd 8-9 goes to NL.
  - SPACE: out_byte = 8'h20. On accept, go to ADDR with digit index = HEXD-1.
  - ADDR: out_byte is the hex nibble at the digit index, MSB first, lowercase (0-9 map to 8'h30-8'h39, a-f map to 8'h61-8'h66), leading zeros included. Pad the upper nibble with zeros when ADDR_BITS is not a multiple of 4. On accept, decrement the index; at index 0, go to NL.
  - NL: out_byte = 8'h0A. On accept, increment rec_count and go to IDLE.
- Accept means out_valid && out_ready. While out_ready=0, state, out_byte and out_valid hold stable; out_valid never drops mid-line.
- Outputs are registered or decoded only from registered state; no combinational path from out_ready to out_byte or out_valid.
- Throughput: one IDLE bubble cycle between lines. Line length is 11 bytes for ADDR_BITS=32 with cmd < 8, and 2 bytes for cmd 8-9.
- Simultaneous events:
  - A push into an empty FIFO and the IDLE check in the same cycle: the pop occurs next cycle (no bypass).
  - Push and pop in the same cycle with the FIFO not full: occupancy is unchanged.
- Counters saturate at all-ones and do not wrap.
- busy=0 only when the FIFO is empty and the FSM is in IDLE.

Test Plan:
- Single line: cmd=1, addr=32'h00001A2B, out_ready=1 → bytes 31 20 30 30 30 30 31 61 32 62 0A (11 bytes, contiguous); rec_count=1; busy falls after NL.
- Short line: cmd=9 → bytes 39 0A only; cmd=8 → bytes 38 0A; rec_count=2.
- Back-pressure: out_ready=0, push records cmd=0, addr=i for i=0..9.
  - One record is popped into the formatter, which stalls in CMD with out_byte=30 held stable.
  - The FIFO then accepts 8 more, so in_ready falls after 9 total accepts.
  - Raising out_ready drains all 9 lines in order; in_ready rises one cycle after the first post-stall pop.
- Illegal command: cmd=12 → accepted (in_ready=1), no bytes emitted, drop_count=1, rec_count unchanged.
- Reset mid-line: assert reset after the 5th byte of cmd=3, addr=32'hDEADBEEF → out_valid=0 immediately, counters=0, FIFO empty; the next record (cmd=2, addr=32'h10) emits 32 20 30 30 30 30 30 30 31 30 0A.
- Random stall: random out_ready (50%) over 200 random legal records → a byte stream matching a reference formatter exactly; rec_count=200.
